aes_key_loader: RTL and testbench

Host-side writer for the key-expansion interface of the AES core. Accepts the cipher key as a stream of 32-bit words over a valid/ready handshake and assembles it into the 256-bit `CipherKey` bus (word 0 in the lowest bits). It checks the word count against the declared key length, then presents `CipherKey`, `Nk` and the `k_ready` strobe to the key-expansion block. It also holds off reloads while expansion is busy.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_key_loader.sv | 124 ++++++++++++
 tb/tb_aes_key_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-loader definitions: key-length encodings, Nk values and
// the loader state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    KLEN_128 = 2'b00,
    KLEN_192 = 2'b01,
    KLEN_256 = 2'b10,
    KLEN_ILL = 2'b11
  } key_len_t;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  function automatic logic [3:0] nk_of(input key_len_t len);
    logic [3:0] nk;
    case (len)
      KLEN_128: nk = NK_128;
      KLEN_192: nk = NK_192;
      KLEN_256: nk = NK_256;
      default:  nk = 4'd0;
    endcase
    return nk;
  endfunction

endpackage

// File: rtl/aes_key_loader.sv
// Assembles a streamed AES cipher key into the 256-bit CipherKey bus and
// hands it to key expansion, checking the word count against key_len.
module aes_key_loader
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [31:0]  key_word,
  input  logic         key_last,
  input  logic [1:0]   key_len,
  input  logic         key_abort,
  input  logic         kexp_busy,
  output logic         key_ready,
  output logic [255:0] CipherKey,
  output logic [3:0]   Nk,
  output logic         k_ready,
  output logic         err
);

  loader_state_t state_q, state_d;
  logic [255:0]  key_q, key_d;
  logic [3:0]    nk_q, nk_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          k_ready_q, k_ready_d;
  logic          err_q, err_d;
  logic          accept;
  logic [3:0]    cnt_inc;

  // Held low during reset so no word is taken while registers are clearing.
  assign key_ready = rst_n && !key_abort && !((state_q == ST_DONE) && kexp_busy);
  assign accept    = key_valid && key_ready;
  assign cnt_inc   = cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    nk_d      = nk_q;
    cnt_d     = cnt_q;
    k_ready_d = k_ready_q;
    err_d     = err_q;

    if (key_abort) begin
      state_d   = ST_IDLE;
      key_d     = '0;
      nk_d      = '0;
      cnt_d     = '0;
      k_ready_d = 1'b0;
      err_d     = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          key_d     = {224'b0, key_word};
          cnt_d     = 4'd1;
          k_ready_d = 1'b0;
          err_d     = 1'b0;
          nk_d      = nk_of(key_len_t'(key_len));
          if (key_len_t'(key_len) == KLEN_ILL) begin
            nk_d    = '0;
            key_d   = '0;
            err_d   = 1'b1;
            state_d = key_last ? ST_IDLE : ST_ERR;
          end else if (key_last) begin
            key_d   = '0;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt_q == nk_q) begin
            key_d   = '0;
            err_d   = 1'b1;
            state_d = key_last ? ST_IDLE : ST_ERR;
          end else begin
            for (int unsigned i = 0; i < 8; i++) begin
              if (cnt_q == i[3:0]) key_d[32*i +: 32] = key_word;
            end
            cnt_d = cnt_inc;
            if (key_last) begin
              if (cnt_inc == nk_q) begin
                state_d   = ST_DONE;
                k_ready_d = 1'b1;
              end else begin
                key_d   = '0;
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_ERR: begin
          if (key_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      nk_q      <= '0;
      cnt_q     <= '0;
      k_ready_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      nk_q      <= nk_d;
      cnt_q     <= cnt_d;
      k_ready_q <= k_ready_d;
      err_q     <= err_d;
    end
  end

  assign CipherKey = key_q;
  assign Nk        = nk_q;
  assign k_ready   = k_ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_key_loader.sv
// Randomized bench for aes_key_loader against a transaction-level model that
// tracks the current key as a queue of words.
module tb_aes_key_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [31:0]  key_word;
  logic         key_last;
  logic [1:0]   key_len;
  logic         key_abort;
  logic         kexp_busy;
  logic         key_ready;
  logic [255:0] CipherKey;
  logic [3:0]   Nk;
  logic         k_ready;
  logic         err;

  aes_key_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_word  (key_word),
    .key_last  (key_last),
    .key_len   (key_len),
    .key_abort (key_abort),
    .kexp_busy (kexp_busy),
    .key_ready (key_ready),
    .CipherKey (CipherKey),
    .Nk        (Nk),
    .k_ready   (k_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode plus the words of the key currently being held.
  typedef enum int {M_IDLE, M_LOAD, M_DONE, M_DRAIN} mode_t;
  mode_t       m_mode;
  logic [31:0] m_words[$];
  logic [3:0]  m_nk;
  logic        m_err;
  logic        m_kready;

  logic        busy_r;
  logic        rand_busy;
  logic        last_acc;

  function automatic void model_reset();
    m_mode   = M_IDLE;
    m_words.delete();
    m_nk     = 4'd0;
    m_err    = 1'b0;
    m_kready = 1'b0;
  endfunction

  function automatic void model_word(input logic [31:0] w, input logic l, input logic [1:0] len);
    case (m_mode)
      M_IDLE, M_DONE: begin
        m_words.delete();
        m_words.push_back(w);
        m_err    = 1'b0;
        m_kready = 1'b0;
        if (len == 2'b11) begin
          m_nk  = 4'd0;
          m_err = 1'b1;
          m_mode = l ? M_IDLE : M_DRAIN;
        end else begin
          m_nk = 4'(4 + 2 * int'(len));
          if (l) begin
            m_err  = 1'b1;
            m_mode = M_IDLE;
          end else begin
            m_mode = M_LOAD;
          end
        end
      end
      M_LOAD: begin
        if (m_words.size() == int'(m_nk)) begin
          m_err  = 1'b1;
          m_mode = l ? M_IDLE : M_DRAIN;
        end else begin
          m_words.push_back(w);
          if (l) begin
            if (m_words.size() == int'(m_nk)) begin
              m_mode   = M_DONE;
              m_kready = 1'b1;
            end else begin
              m_err  = 1'b1;
              m_mode = M_IDLE;
            end
          end
        end
      end
      M_DRAIN: if (l) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endfunction

  function automatic logic [255:0] model_key();
    logic [255:0] k;
    k = '0;
    if (m_mode == M_LOAD || m_mode == M_DONE) begin
      for (int i = 0; i < m_words.size() && i < 8; i++) k[32*i +: 32] = m_words[i];
    end
    return k;
  endfunction

  task automatic check_outputs();
    check("CipherKey", CipherKey, model_key());
    check("Nk", 256'(Nk), 256'(m_nk));
    check("k_ready", 256'(k_ready), 256'(m_kready));
    check("err", 256'(err), 256'(m_err));
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic l,
                      input logic [1:0] len, input logic ab, input logic busy);
    logic rdy;
    key_valid = v;
    key_word  = w;
    key_last  = l;
    key_len   = len;
    key_abort = ab;
    kexp_busy = busy;
    #1;
    rdy = !ab && !(m_mode == M_DONE && busy);
    check("key_ready", 256'(key_ready), 256'(rdy));
    last_acc = v && rdy;
    @(posedge clk);
    if (ab) model_reset();
    else if (last_acc) model_word(w, l, len);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b0, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, busy_r);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input logic [1:0] len);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      step(1'b1, w, l, len, 1'b0, busy_r);
      done = last_acc;
      if (!done && rand_busy) busy_r = 1'($urandom_range(0, 1));
    end
    if (!done) check("send_timeout", 256'(done), 256'(1));
  endtask

  task automatic send_key(input int nwords, input logic [1:0] len, input logic gaps, input int abort_at);
    for (int i = 0; i < nwords; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle_step();
      if (i == abort_at) begin
        step(1'($urandom_range(0, 1)), $urandom, 1'b0, len, 1'b1, busy_r);
        return;
      end
      if (rand_busy) busy_r = 1'($urandom_range(0, 1));
      send_word($urandom, i == nwords - 1, len);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_key_ready", 256'(key_ready), 256'(0));
    check_outputs();
    #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] dir_words[4];
  logic [31:0] w0;

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_word = '0; key_last = 1'b0;
    key_len = 2'b00; key_abort = 1'b0; kexp_busy = 1'b0;
    busy_r = 1'b0; rand_busy = 1'b0; last_acc = 1'b0;
    model_reset();
    #1;
    check("rst_key_ready", 256'(key_ready), 256'(0));
    check_outputs();
    #10;
    rst_n = 1'b1;

    // 128-bit back-to-back load
    dir_words[0] = 32'h00010203; dir_words[1] = 32'h04050607;
    dir_words[2] = 32'h08090a0b; dir_words[3] = 32'h0c0d0e0f;
    for (int i = 0; i < 4; i++) send_word(dir_words[i], i == 3, 2'b00);
    check("dir128_key", CipherKey, 256'h0c0d0e0f_08090a0b_04050607_00010203);

    // 256-bit with gaps, then 192-bit reload held off by busy
    send_key(8, 2'b10, 1'b1, -1);
    busy_r = 1'b1;
    w0 = $urandom;
    repeat (3) step(1'b1, w0, 1'b0, 2'b01, 1'b0, busy_r);
    busy_r = 1'b0;
    send_word(w0, 1'b0, 2'b01);
    send_key(5, 2'b01, 1'b0, -1);
    check("dir192_upper", 256'(CipherKey[255:192]), 256'(0));

    send_key(6, 2'b10, 1'b0, -1);   // short 256-bit key
    idle_step();
    send_key(6, 2'b00, 1'b0, -1);   // overlength 128-bit key
    send_key(4, 2'b00, 1'b0, -1);
    send_key(4, 2'b11, 1'b0, -1);   // illegal length
    idle_step();

    send_key(6, 2'b01, 1'b0, 3);    // abort in LOAD after word 2
    idle_step();
    send_key(4, 2'b00, 1'b0, -1);
    reset_pulse();
    idle_step();

    rand_busy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [1:0] len;
      int nk, n, ab_at;
      len = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      nk  = (len == 2'b11) ? 4 : 4 + 2 * int'(len);
      n   = nk + int'($urandom_range(0, 4)) - 2;
      if ($urandom_range(0, 3) == 0) n = nk;
      if (n < 1) n = 1;
      ab_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_key(n, len, 1'($urandom_range(0, 1)), ab_at);
      repeat ($urandom_range(0, 2)) idle_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
